// File: rtl/step_timer.sv
// Programmable down-counting step timer: counts out a loaded period and emits a
// registered one-cycle tick, with run/pause/stop control and a one-shot mode.
module step_timer #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    count_d  = count_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;

    if (load) begin
      // load outranks stop/start/counting; a zero period disables the timer
      reload_d = period;
      count_d  = period;
      if (state_q == IDLE) begin
        if (start && (period != '0)) begin
          state_d = RUN;
          mode_d  = oneshot;
        end
      end else if (period == '0) begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (reload_q != '0)) begin
            state_d = RUN;
            count_d = reload_q;
            mode_d  = oneshot;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            tick_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
              state_d = IDLE;
            end else begin
              count_d = reload_q;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_d = IDLE;
            count_d = '0;
          end else if (start) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_step_timer.sv
// Directed self-checking bench for step_timer with hand-computed expectations.
module tb_step_timer;

  localparam int unsigned WIDTH = 20;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] period = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             oneshot = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;

  int checks = 0;
  int failures = 0;

  step_timer #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .load(load), .period(period),
    .start(start), .stop(stop), .oneshot(oneshot),
    .count(count), .tick(tick), .busy(busy)
  );

  always #5 clock = ~clock;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input int p);
    load = 1'b1; period = WIDTH'(p);
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clock);
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_periodic();
    int exp_c;
    logic exp_t;
    do_load(5);
    checks++; if (count !== 20'd5) begin failures++; $display("FAIL per_load_count got=%0d exp=5", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL per_load_busy got=%b exp=0", busy); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (count !== 20'd5) begin failures++; $display("FAIL per_start_count got=%0d exp=5", count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL per_start_busy got=%b exp=1", busy); end
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_c = 5 - (k % 5);
      exp_t = ((k % 5) == 0);
      checks++; if (count !== WIDTH'(exp_c)) begin failures++; $display("FAIL per_count k=%0d got=%0d exp=%0d", k, count, exp_c); end
      checks++; if (tick !== exp_t) begin failures++; $display("FAIL per_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
    end
    stop = 1'b1; step(); step(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL per_stop_busy got=%b exp=0", busy); end
    checks++; if (count !== '0) begin failures++; $display("FAIL per_stop_count got=%0d exp=0", count); end
  endtask

  task automatic test_oneshot();
    do_load(3);
    oneshot = 1'b1; start = 1'b1; step(); oneshot = 1'b0; start = 1'b0;
    checks++; if (count !== 20'd3 || busy !== 1'b1) begin failures++; $display("FAIL os_start got=%0d/%b exp=3/1", count, busy); end
    step();
    checks++; if (count !== 20'd2 || tick !== 1'b0) begin failures++; $display("FAIL os_k1 got=%0d/%b exp=2/0", count, tick); end
    step();
    checks++; if (count !== 20'd1 || tick !== 1'b0) begin failures++; $display("FAIL os_k2 got=%0d/%b exp=1/0", count, tick); end
    step();
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL os_tick got=%b exp=1", tick); end
    checks++; if (count !== '0) begin failures++; $display("FAIL os_tick_count got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL os_tick_busy got=%b exp=0", busy); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (tick !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL os_quiet k=%0d got=%b/%b exp=0/0", k, tick, busy); end
    end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 20'd3) begin failures++; $display("FAIL os_restart got=%b/%0d exp=1/3", busy, count); end
    stop = 1'b1; step(); step(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL os_restart_stop got=%b exp=0", busy); end
  endtask

  task automatic test_pause();
    do_load(4);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    checks++; if (count !== 20'd2) begin failures++; $display("FAIL pz_pre got=%0d exp=2", count); end
    stop = 1'b1; step(); stop = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      checks++; if (count !== 20'd2 || busy !== 1'b1 || tick !== 1'b0) begin failures++; $display("FAIL pz_hold k=%0d got=%0d/%b/%b exp=2/1/0", k, count, busy, tick); end
    end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (count !== 20'd2 || tick !== 1'b0) begin failures++; $display("FAIL pz_resume got=%0d/%b exp=2/0", count, tick); end
    step();
    checks++; if (count !== 20'd1 || tick !== 1'b0) begin failures++; $display("FAIL pz_r1 got=%0d/%b exp=1/0", count, tick); end
    step();
    checks++; if (count !== 20'd4 || tick !== 1'b1) begin failures++; $display("FAIL pz_tick got=%0d/%b exp=4/1", count, tick); end
    step();
    stop = 1'b1; step();
    checks++; if (count !== 20'd3 || busy !== 1'b1) begin failures++; $display("FAIL pz_pause2 got=%0d/%b exp=3/1", count, busy); end
    step(); stop = 1'b0;
    checks++; if (count !== '0 || busy !== 1'b0) begin failures++; $display("FAIL pz_idle got=%0d/%b exp=0/0", count, busy); end
  endtask

  task automatic test_load_zero();
    do_load(6);
    start = 1'b1; step(); start = 1'b0;
    step();
    checks++; if (count !== 20'd5) begin failures++; $display("FAIL lz_pre got=%0d exp=5", count); end
    do_load(0);
    checks++; if (count !== '0 || busy !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL lz_idle got=%0d/%b/%b exp=0/0/0", count, busy, tick); end
    start = 1'b1; step(); step(); start = 1'b0;
    checks++; if (busy !== 1'b0 || count !== '0) begin failures++; $display("FAIL lz_start got=%b/%0d exp=0/0", busy, count); end
  endtask

  task automatic test_simultaneous();
    load = 1'b1; period = 20'd8; start = 1'b1; step(); load = 1'b0; start = 1'b0;
    checks++; if (count !== 20'd8 || busy !== 1'b1) begin failures++; $display("FAIL sim_ldst got=%0d/%b exp=8/1", count, busy); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (tick !== (k == 8)) begin failures++; $display("FAIL sim_tick k=%0d got=%b exp=%b", k, tick, (k == 8)); end
    end
    checks++; if (count !== 20'd8) begin failures++; $display("FAIL sim_reload got=%0d exp=8", count); end
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    step();
    checks++; if (count !== 20'd8 || busy !== 1'b1) begin failures++; $display("FAIL sim_stst_pause got=%0d/%b exp=8/1", count, busy); end
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    checks++; if (count !== 20'd6) begin failures++; $display("FAIL sim_pre_load got=%0d exp=6", count); end
    do_load(2);
    checks++; if (count !== 20'd2 || tick !== 1'b0) begin failures++; $display("FAIL sim_load2 got=%0d/%b exp=2/0", count, tick); end
    step();
    checks++; if (count !== 20'd1 || tick !== 1'b0) begin failures++; $display("FAIL sim_l1 got=%0d/%b exp=1/0", count, tick); end
    step();
    checks++; if (count !== 20'd2 || tick !== 1'b1) begin failures++; $display("FAIL sim_l2_tick got=%0d/%b exp=2/1", count, tick); end
    stop = 1'b1; step(); step(); stop = 1'b0;
  endtask

  task automatic test_period_one();
    do_load(1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (tick !== 1'b1 || count !== 20'd1) begin failures++; $display("FAIL p1_tick k=%0d got=%b/%0d exp=1/1", k, tick, count); end
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (tick !== 1'b0 || count !== 20'd1) begin failures++; $display("FAIL p1_stop got=%b/%0d exp=0/1", tick, count); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL p1_resume got=%b exp=0", tick); end
    step();
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL p1_after_resume got=%b exp=1", tick); end
    stop = 1'b1; step(); step(); stop = 1'b0;
  endtask

  task automatic test_async_reset();
    do_load(2);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    checks++; if (tick !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b/%b exp=1/1", tick, busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== '0 || tick !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ar_async got=%0d/%b/%b exp=0/0/0", count, tick, busy); end
    @(negedge clock);
    reset = 1'b0;
    start = 1'b1; step(); step(); start = 1'b0;
    checks++; if (busy !== 1'b0 || count !== '0 || tick !== 1'b0) begin failures++; $display("FAIL ar_after got=%b/%0d/%b exp=0/0/0", busy, count, tick); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_load_zero();
    test_simultaneous();
    test_period_one();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
